send_acknak: RTL
================

# send_acknak

Transmit-side handshake packet generator for the USB host/device link. On request it serializes a complete ACK or NAK handshake packet (SYNC, PID, EOP) onto the D+/D- lines with NRZI encoding, one bit per non-paused clock. It is the sending counterpart of the handshake receiver, and shares the same bit-time `pause` stall convention.

## Interface
Parameters:
- none. Packet format and bit counts are fixed by protocol.

Ports:
- `clk` in 1: system clock.
- `rst_L` in 1: reset, asynchronous, active-low.
- `pause` in 1: stall. While 1, state, counters and line outputs hold.
- `send_hand` in 1: request to send a handshake. Level-sampled in IDLE.
- `send_ack` in 1: 1 = ACK (PID 4'b0010), 0 = NAK (PID 4'b1010). Sampled with `send_hand`.
- `dp` out 1: D+ line value (registered).
- `dm` out 1: D- line value (registered).
- `bus_en` out 1: line driver enable (registered).
- `busy` out 1: high while a packet is in progress (state != IDLE).
- `done` out 1: one-clk pulse at packet completion.

## Operation
- Line encodings:
  - J = (`dp`=1, `dm`=0).
  - K = (0,1).
  - SE0 = (0,0).
  - Idle/undriven value is J.
- Bit stream, in transmit order:
  - SYNC: 0,0,0,0,0,0,0,1.
  - PID: pid[0..3] LSB first, then ~pid[0..3].
  - EOP: SE0, SE0, J.
- NRZI: a data bit 0 toggles the line (J<->K); a data bit 1 holds it. The encoder's line state is J at packet start.
- No bit stuffing. Neither fixed pattern contains six consecutive 1s.
- PID is latched at acceptance. A later change of `send_ack` has no effect on a packet in flight.
- FSM states (3-bit):
  - IDLE: accept when `send_hand`=1 and `pause`=0 → SYNC.
  - SYNC: 8 bit times, 3-bit bit counter. Counter==7 → PID.
  - PID: 8 bit times, counter reused. Counter==7 → EOP_SE0.
  - EOP_SE0: 2 bit times. Then → EOP_J.
  - EOP_J: 1 bit time. Then → IDLE, assert `done`.
- A bit time is exactly one clock edge with `pause`=0. Paused edges change nothing, except that `done` still clears.
- `send_hand` is ignored while `busy`=1. It is not queued.

## Timing
- Reset values:
  - `dp`=1, `dm`=0, `bus_en`=0, `busy`=0, `done`=0.
  - State IDLE, counters 0, latched PID 0.
- Reset mid-packet aborts immediately to these values. Lines return to J with the driver off.
- Accept edge (IDLE, `send_hand`=1, `pause`=0):
  - Outputs update to the first SYNC bit (K).
  - `bus_en`=1 and `busy`=1 on that same edge.
- Bit i (0..18) is presented during the cycle after the i-th non-paused edge counted from acceptance. Total: 19 bit times. Unpaused latency from request to end of EOP is 19 cycles.
- Finish edge (non-paused edge after bit 18):
  - `bus_en`=0, lines J, `busy`=0, `done`=1.
  - `done` clears on the next clk edge regardless of `pause`.
- Back-to-back requests: `send_hand` held high through `done` is accepted at the next non-paused edge. This guarantees at least one idle bit time between packets.
- `send_hand`=1 with `pause`=1 in IDLE: not accepted until an edge with `pause`=0.

## Test plan
- Reset:
  - Assert `rst_L`=0 mid-SYNC → `dp`=1, `dm`=0, `bus_en`=0, `busy`=0, `done`=0 immediately.
  - After release, the FSM stays IDLE until a request.
- ACK, `pause`=0: one-cycle `send_hand`=1, `send_ack`=1.
  - `dp` over 19 cycles: 0,1,0,1,0,1,0,0 | 1,1,0,1,1,0,0,0 | 0,0 | 1.
  - `dm` = ~`dp` except 0 during both SE0 cycles.
  - `bus_en` high for exactly 19 cycles.
  - `done` pulses once, in cycle 20.
- NAK: `send_ack`=0.
  - PID `dp` segment: 1,1,0,0,0,1,1,0.
  - SYNC and EOP identical to the ACK case.
- Pause: assert `pause` for 3 cycles at bit 5 and for 2 cycles at bit 17 (SE0).
  - Lines hold during the pauses.
  - Total `bus_en` high = 24 cycles.
  - Bit sequence unchanged.
- Ignore while busy, and PID latching:
  - Pulse `send_hand` at bit 10 with `send_ack` flipped → packet unaffected. No second packet starts.
  - Toggle `send_ack` mid-PID → encoded PID still matches the value latched at acceptance.
- Back-to-back: hold `send_hand`=1 continuously → packets separated by exactly one idle J cycle (the `done` cycle). `done` pulses once per packet.

Source files
------------

// File: rtl/send_acknak_if.sv
// Request and line-side signals of the USB handshake packet transmitter.
// The master side requests packets; the slave side (the transmitter) drives the lines.
interface send_acknak_if;
  logic pause;
  logic send_hand;
  logic send_ack;
  logic dp;
  logic dm;
  logic bus_en;
  logic busy;
  logic done;

  modport master (
    output pause, send_hand, send_ack,
    input  dp, dm, bus_en, busy, done
  );

  modport slave (
    input  pause, send_hand, send_ack,
    output dp, dm, bus_en, busy, done
  );
endinterface

// File: rtl/send_acknak.sv
// Serializes an ACK/NAK handshake packet (SYNC, PID, EOP) onto D+/D- with NRZI,
// one bit per non-paused clock.
module send_acknak (
  input logic          clk,
  input logic          rst_L,
  send_acknak_if.slave link
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SYNC    = 3'd1,
    PID     = 3'd2,
    EOP_SE0 = 3'd3,
    EOP_J   = 3'd4
  } state_t;

  state_t     state, state_n;
  logic [2:0] cnt, cnt_n;
  logic [3:0] pid, pid_n;
  logic       dp_q, dp_n;
  logic       dm_q, dm_n;
  logic       bus_en_q, bus_en_n;
  logic       done_q, done_n;
  logic       data;
  logic       nrzi_en;

  always_ff @(posedge clk or negedge rst_L) begin
    if (!rst_L) begin
      state    <= IDLE;
      cnt      <= 3'd0;
      pid      <= 4'd0;
      dp_q     <= 1'b1;
      dm_q     <= 1'b0;
      bus_en_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      pid      <= pid_n;
      dp_q     <= dp_n;
      dm_q     <= dm_n;
      bus_en_q <= bus_en_n;
      done_q   <= done_n;
    end
  end

  // State/cnt describe the bit being presented; each unpaused edge moves to the next bit.
  // dp_q doubles as the NRZI line state (J when dp=1).
  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    pid_n    = pid;
    dp_n     = dp_q;
    dm_n     = dm_q;
    bus_en_n = bus_en_q;
    done_n   = 1'b0;
    data     = 1'b1;
    nrzi_en  = 1'b0;

    if (!link.pause) begin
      case (state)
        IDLE: begin
          if (link.send_hand) begin
            pid_n    = link.send_ack ? 4'b0010 : 4'b1010;
            state_n  = SYNC;
            cnt_n    = 3'd0;
            dp_n     = 1'b0;
            dm_n     = 1'b1;
            bus_en_n = 1'b1;
          end
        end
        SYNC: begin
          nrzi_en = 1'b1;
          if (cnt == 3'd7) begin
            state_n = PID;
            cnt_n   = 3'd0;
            data    = pid[0];
          end else begin
            cnt_n = cnt + 3'd1;
            data  = (cnt_n == 3'd7);
          end
        end
        PID: begin
          if (cnt == 3'd7) begin
            state_n = EOP_SE0;
            cnt_n   = 3'd0;
            dp_n    = 1'b0;
            dm_n    = 1'b0;
          end else begin
            nrzi_en = 1'b1;
            cnt_n   = cnt + 3'd1;
            data    = cnt_n[2] ? ~pid[cnt_n[1:0]] : pid[cnt_n[1:0]];
          end
        end
        EOP_SE0: begin
          if (cnt[0]) begin
            state_n = EOP_J;
            cnt_n   = 3'd0;
            dp_n    = 1'b1;
            dm_n    = 1'b0;
          end else begin
            cnt_n = 3'd1;
          end
        end
        EOP_J: begin
          state_n  = IDLE;
          cnt_n    = 3'd0;
          dp_n     = 1'b1;
          dm_n     = 1'b0;
          bus_en_n = 1'b0;
          done_n   = 1'b1;
        end
        default: begin
          state_n = IDLE;
        end
      endcase

      if (nrzi_en) begin
        dp_n = data ? dp_q : ~dp_q;
        dm_n = ~dp_n;
      end
    end
  end

  assign link.dp     = dp_q;
  assign link.dm     = dm_q;
  assign link.bus_en = bus_en_q;
  assign link.busy   = (state != IDLE);
  assign link.done   = done_q;

endmodule
